// File: rtl/uart_rx_mmio.sv
// UART 8N1 receiver with a small byte FIFO, exposed as one memory-mapped status/data word.
`timescale 1ns/1ps
module uart_rx_mmio #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        rd_ack,
  output logic [31:0] uart_data,
  output logic        rx_busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned HALF         = CLKS_PER_BIT / 2;
  localparam int unsigned CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PW           = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned NW           = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Synchroniser, receiver and FIFO state
  logic          sync1_q, sync1_d;
  logic          rxs_q, rxs_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic          ovr_q, ovr_d;
  logic          ferr_q, ferr_d;

  logic push_c, ferr_set_c, pop_c, full_c, wr_c, valid_c;

  // Two-flop synchroniser; the line idles high so both stages reset to 1
  always_comb begin
    sync1_d = rx;
    rxs_d   = sync1_q;
  end

  // Frame FSM: counter-driven mid-bit sampling of start, 8 data bits and stop
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    push_c     = 1'b0;
    ferr_set_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = CW'(HALF - 1);
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (!rxs_q) begin
            state_d = S_DATA;
            cnt_d   = CW'(CLKS_PER_BIT - 1);
            bit_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rxs_q, shift_q[7:1]};
          cnt_d   = CW'(CLKS_PER_BIT - 1);
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          if (rxs_q) begin
            push_c  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_set_c = 1'b1;
            state_d    = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_BREAK: begin
        // Wait out a held-low line so it reports one frame error only
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO push/pop and sticky flags; a pop frees the slot for a same-cycle push
  always_comb begin
    pop_c    = rd_ack && (count_q != '0);
    full_c   = (count_q == NW'(FIFO_DEPTH));
    wr_c     = push_c && (!full_c || pop_c);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_c) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({wr_c, pop_c})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
    if (push_c && full_c && !pop_c) begin
      ovr_d = 1'b1;
    end else if (rd_ack) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
    if (ferr_set_c) begin
      ferr_d = 1'b1;
    end else if (rd_ack) begin
      ferr_d = 1'b0;
    end else begin
      ferr_d = ferr_q;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      rxs_q    <= 1'b1;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      rxs_q    <= rxs_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
    end
  end

  // Status/data word seen by the load mux
  always_comb begin
    valid_c   = (count_q != '0);
    uart_data = {valid_c, ovr_q, ferr_q, 21'd0, (valid_c ? mem_q[rd_ptr_q] : 8'h00)};
    rx_busy   = (state_q != S_IDLE);
  end

endmodule
